dac_stream_model: RTL and testbench

- Behavioural DAC transmitter model; the digital-to-analog counterpart of the ADC front-end.
- Accepts digital codes over a valid/ready stream and buffers them in a small FIFO.
- Drives a real-valued analog output, scaled by a PGA-style gain select.
- Sequences each sample through a settle interval and then a hold interval, flagging when the output is settled and when the stream runs dry.

---
 rtl/dac_stream_pkg.sv | 28 ++
 rtl/dac_sample_fifo.sv | 77 +++++++
 rtl/dac_stream_model.sv | 127 ++++++++++++
 tb/tb_dac_stream_model.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/dac_stream_pkg.sv
// Shared types and constants for the DAC stream model: FSM states, gain
// factors, the FIFO entry layout and the code-to-analog conversion.
package dac_stream_pkg;

  localparam int CODE_W     = 8;
  localparam int HOLD_WIDTH = 4;

  localparam real GAIN_LO = 1.0;
  localparam real GAIN_HI = 3.0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0]     code;
    logic                  gain;
    logic [HOLD_WIDTH-1:0] hold;
  } entry_t;

  // The code is unsigned, so full-scale converts exactly.
  function automatic real entry_to_real(input entry_t e, input real lsb);
    return real'(e.code) * lsb * (e.gain ? GAIN_HI : GAIN_LO);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous FIFO of DAC entries. The ready flag is registered and
// reflects "not full" so a full FIFO never accepts a push, even alongside a pop.
module dac_sample_fifo
  import dac_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 pop_data,
  output logic                   ready,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_nxt_s;
  logic          ready_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests and compute next occupancy.
  always_comb begin
    do_push_s = push && ready_r;
    do_pop_s  = pop && (level_r != '0);
    if (do_push_s && !do_pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (!do_push_s && do_pop_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      ready_r  <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != LVL_FULL);
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign ready    = ready_r;
  assign empty    = (level_r == '0);
  assign level    = level_r;

endmodule

// File: rtl/dac_stream_model.sv
// Behavioural DAC transmitter: buffers codes, then plays each one out
// through a settle interval and a hold interval on a real-valued output.
module dac_stream_model
  import dac_stream_pkg::*;
#(
  parameter int  WIDTH         = CODE_W,
  parameter int  DEPTH         = 4,
  parameter int  SETTLE_CYCLES = 2,
  parameter int  HOLD_W        = HOLD_WIDTH,
  parameter real LSB           = 1.0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_code,
  input  logic                   gain,
  input  logic [HOLD_W-1:0]      hold_cycles,
  output real                    out,
  output logic                   out_settled,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int HOLD_MAX = (1 << HOLD_W) - 1;
  localparam int CNT_MAX  = (SETTLE_CYCLES > HOLD_MAX) ? SETTLE_CYCLES : HOLD_MAX;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [HOLD_WIDTH-1:0] hold_r;
  real                   out_r;
  logic                  settled_r;
  logic                  underrun_r;
  entry_t                push_entry_s;
  entry_t                head_s;
  logic                  empty_s;
  logic                  pop_s;

  // Pack the incoming sample and decide whether this edge pops the FIFO.
  always_comb begin
    push_entry_s.code = CODE_W'(in_code);
    push_entry_s.gain = gain;
    push_entry_s.hold = HOLD_WIDTH'(hold_cycles);
    if (state_r == IDLE) begin
      pop_s = !empty_s;
    end else if ((state_r == HOLD) && (cnt_r == CNT_ONE)) begin
      pop_s = !empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  dac_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .push_data(push_entry_s),
    .pop      (pop_s),
    .pop_data (head_s),
    .ready    (in_ready),
    .empty    (empty_s),
    .level    (level)
  );

  // Sample sequencer: load, settle, hold, then reload or report underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      hold_r     <= '0;
      out_r      <= 0.0;
      settled_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            out_r     <= entry_to_real(head_s, LSB);
            hold_r    <= head_s.hold;
            settled_r <= 1'b0;
            cnt_r     <= CNT_SETTLE;
            state_r   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_r == CNT_ONE) begin
            settled_r <= 1'b1;
            cnt_r     <= (hold_r == '0) ? CNT_ONE : CNT_W'(hold_r);
            state_r   <= HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_r != CNT_ONE) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else if (pop_s) begin
            out_r     <= entry_to_real(head_s, LSB);
            hold_r    <= head_s.hold;
            settled_r <= 1'b0;
            cnt_r     <= CNT_SETTLE;
            state_r   <= SETTLE;
          end else begin
            settled_r  <= 1'b0;
            underrun_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        default: begin
          settled_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign out         = out_r;
  assign out_settled = settled_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_dac_stream_model.sv
// Directed self-checking bench for dac_stream_model with hand-computed
// expectations at each edge of interest.
module tb_dac_stream_model;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       gain;
  logic [3:0] hold_cycles;
  real        out;
  logic       out_settled;
  logic       underrun;
  logic [2:0] level;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  dac_stream_model dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .gain       (gain),
    .hold_cycles(hold_cycles),
    .out        (out),
    .out_settled(out_settled),
    .underrun   (underrun),
    .level      (level)
  );

  task automatic check(input string tag, input real obs, input real exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: observed %0.3f expected %0.3f", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample across the next edge; in_valid stays high afterwards.
  task automatic push(input logic [7:0] c, input logic g, input logic [3:0] h);
    in_valid    = 1'b1;
    in_code     = c;
    gain        = g;
    hold_cycles = h;
    tick();
  endtask

  initial begin
    real exp_out;
    real exp_lvl;
    rst = 1'b1; in_valid = 1'b0; in_code = 8'd0; gain = 1'b0; hold_cycles = 4'd0;
    tick(); tick();
    check("rst_out", out, 0.0);
    check("rst_settled", out_settled, 0.0);
    check("rst_underrun", underrun, 0.0);
    check("rst_level", level, 0.0);
    check("rst_ready", in_ready, 0.0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", in_ready, 1.0);

    // Single sample, hold 3
    push(8'd5, 1'b0, 4'd3); in_valid = 1'b0;
    check("t1_level", level, 1.0);
    check("t1_out_e0", out, 0.0);
    tick();
    check("t1_out_e1", out, 5.0);
    check("t1_settled_e1", out_settled, 0.0);
    tick(); tick();
    check("t1_settled_e3", out_settled, 1.0);
    tick(); tick();
    check("t1_settled_e5", out_settled, 1.0);
    check("t1_underrun_e5", underrun, 0.0);
    tick();
    check("t1_settled_e6", out_settled, 0.0);
    check("t1_underrun_e6", underrun, 1.0);
    check("t1_out_e6", out, 5.0);
    tick();
    check("t1_underrun_e7", underrun, 0.0);
    check("t1_out_e7", out, 5.0);

    // Gain x3, then code 0 back-to-back
    push(8'd10, 1'b1, 4'd1);
    push(8'd0, 1'b1, 4'd1); in_valid = 1'b0;
    check("t2_out_gain", out, 30.0);
    tick(); tick();
    check("t2_settled", out_settled, 1.0);
    check("t2_out_hold", out, 30.0);
    tick();
    check("t2_out_zero", out, 0.0);
    check("t2_settled_reload", out_settled, 0.0);
    check("t2_no_underrun", underrun, 0.0);
    tick(); tick(); tick();
    check("t2_underrun", underrun, 1.0);

    // Three codes back-to-back, hold 2
    push(8'd1, 1'b0, 4'd2);
    push(8'd2, 1'b0, 4'd2);
    push(8'd3, 1'b0, 4'd2); in_valid = 1'b0;
    check("t3_out_b2", out, 1.0);
    check("t3_level_b2", level, 2.0);
    for (int c = 3; c <= 13; c++) begin
      tick();
      exp_out = (c < 5) ? 1.0 : (c < 9) ? 2.0 : 3.0;
      check($sformatf("t3_out_b%0d", c), out, exp_out);
      check($sformatf("t3_underrun_b%0d", c), underrun, (c == 13) ? 1.0 : 0.0);
    end

    // Fill the FIFO while the first sample plays
    push(8'd20, 1'b0, 4'd2);
    check("t4_ready_c0", in_ready, 1.0);
    push(8'd21, 1'b0, 4'd2);
    check("t4_out_c1", out, 20.0);
    push(8'd22, 1'b0, 4'd2);
    push(8'd23, 1'b0, 4'd2);
    check("t4_ready_c3", in_ready, 1.0);
    push(8'd24, 1'b0, 4'd2);
    check("t4_level_full", level, 4.0);
    check("t4_ready_full", in_ready, 0.0);
    push(8'd25, 1'b0, 4'd2); in_valid = 1'b0;
    check("t4_level_c5", level, 3.0);
    check("t4_out_c5", out, 21.0);
    check("t4_ready_c5", in_ready, 1.0);
    for (int c = 6; c <= 21; c++) begin
      tick();
      exp_out = (c < 9) ? 21.0 : (c < 13) ? 22.0 : (c < 17) ? 23.0 : 24.0;
      exp_lvl = (c < 9) ? 3.0 : (c < 13) ? 2.0 : (c < 17) ? 1.0 : 0.0;
      check($sformatf("t4_out_c%0d", c), out, exp_out);
      check($sformatf("t4_level_c%0d", c), level, exp_lvl);
      check($sformatf("t4_underrun_c%0d", c), underrun, (c == 21) ? 1.0 : 0.0);
    end

    // hold_cycles = 0 behaves as 1
    push(8'd9, 1'b0, 4'd0); in_valid = 1'b0;
    tick();
    check("t5_out", out, 9.0);
    tick(); tick();
    check("t5_settled_d3", out_settled, 1.0);
    tick();
    check("t5_settled_d4", out_settled, 0.0);
    check("t5_underrun_d4", underrun, 1.0);

    // Reset mid-HOLD with two entries queued
    push(8'd7, 1'b0, 4'd5);
    push(8'd8, 1'b0, 4'd5);
    push(8'd9, 1'b0, 4'd5); in_valid = 1'b0;
    tick();
    check("t6_out_hold", out, 7.0);
    check("t6_level_hold", level, 2.0);
    check("t6_settled_hold", out_settled, 1.0);
    rst = 1'b1;
    tick();
    check("t6_rst_out", out, 0.0);
    check("t6_rst_level", level, 0.0);
    check("t6_rst_settled", out_settled, 0.0);
    check("t6_rst_underrun", underrun, 0.0);
    check("t6_rst_ready", in_ready, 0.0);
    rst = 1'b0;
    tick();
    check("t6_ready_after", in_ready, 1.0);
    check("t6_underrun_after", underrun, 0.0);
    check("t6_out_after", out, 0.0);
    tick();
    check("t6_underrun_later", underrun, 0.0);
    check("t6_level_later", level, 0.0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
